// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out stream shifter.
// No logic: state encoding and bit-order constants only.
// Imported by piso_stream.
package piso_pkg;

   // State encoding of the shifter FSM
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // Bit order selector values, sampled with the parallel word
   localparam logic ORDER_LSB = 1'b0;
   localparam logic ORDER_MSB = 1'b1;

   typedef enum logic {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT
   } piso_state_t;

endpackage

// File: rtl/piso_stream.sv
// Parallel word in, one bit per consumed cycle out, per-frame MSB/LSB-first order.
// Latency: first bit on dout the cycle after the load handshake; WIDTH cycles per frame unstalled.
// Backpressure: shift_en=0 freezes the frame; load_ready only in IDLE or on the consumed last bit.
module piso_stream
   import piso_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   input  logic             msb_first,
   input  logic             shift_en,
   output logic             dout,
   output logic             dout_valid,
   output logic             last,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   piso_state_t      state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             dir, dir_nx;

   logic             in_shift;
   logic             last_bit;
   logic             consume;
   logic             accept;

   // Handshake and frame-position decode; load_ready never looks at load_valid
   always_comb begin
      in_shift   = (state == SHIFT);
      last_bit   = in_shift && (cnt == CNT_LAST);
      consume    = in_shift && shift_en;
      load_ready = !in_shift || (last_bit && shift_en);
      accept     = load_valid && load_ready;
   end

   // Next-state: a load wins over the frame end so back-to-back words leave no gap
   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      cnt_nx   = cnt;
      dir_nx   = dir;
      if (accept) begin
         state_nx = SHIFT;
         sreg_nx  = din;
         dir_nx   = msb_first;
         cnt_nx   = '0;
      end else if (consume) begin
         // Move the next bit toward the output end, zero-filling behind it
         if (dir == ORDER_LSB) begin
            sreg_nx = {1'b0, sreg[WIDTH-1:1]};
         end else begin
            sreg_nx = {sreg[WIDTH-2:0], 1'b0};
         end
         if (last_bit) begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx = cnt + CNT_W'(1);
         end
      end
   end

   // State registers; reset discards any frame in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         dir   <= ORDER_MSB;
      end else begin
         state <= state_nx;
         sreg  <= sreg_nx;
         cnt   <= cnt_nx;
         dir   <= dir_nx;
      end
   end

   // Serial outputs are forced quiet outside a frame
   always_comb begin
      dout       = 1'b0;
      dout_valid = in_shift;
      busy       = in_shift;
      last       = last_bit;
      if (in_shift) begin
         dout = (dir == ORDER_MSB) ? sreg[WIDTH-1] : sreg[0];
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: a WIDTH=4 and a WIDTH=8 instance against a bit-queue model.
// Directed frames pin the model with literal streams, then random traffic runs.
// Single process drives inputs, steps the model and compares each cycle.
module tb_piso_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       lv4, lv8, sen, msb;
   logic [3:0] d4;
   logic [7:0] d8;
   logic       r4, o4, v4, l4, b4;
   logic       r8, o8, v8, l8, b8;

   int cmp_n = 0;
   int mis_n = 0;

   // Model: pending frame bits in emission order, bit 0 goes out next
   logic [15:0] pend [2];
   int          plen [2];

   // Capture of DUT valid bits (newest in bit 0) and last flags
   logic [63:0] cap  [2];
   logic [63:0] lcap [2];
   int          ncap [2];
   logic        rdy_s [2];

   always #5 clk = ~clk;

   piso_stream #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(r4), .din(d4),
      .msb_first(msb), .shift_en(sen), .dout(o4), .dout_valid(v4), .last(l4), .busy(b4)
   );

   piso_stream #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(r8), .din(d8),
      .msb_first(msb), .shift_en(sen), .dout(o8), .dout_valid(v8), .last(l8), .busy(b8)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         mis_n++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         pend[i] = '0;
         plen[i] = 0;
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge
   task automatic tick();
      logic [4:0]  ao [2];
      logic        erdy, ed;
      string       pfx;
      logic        lvi;
      logic [7:0]  di;
      int          w;
      @(negedge clk);
      ao[0] = {r4, o4, v4, l4, b4};
      ao[1] = {r8, o8, v8, l8, b8};
      for (int i = 0; i < 2; i++) begin
         pfx  = (i == 0) ? "w4" : "w8";
         erdy = (plen[i] == 0) || (plen[i] == 1 && sen);
         ed   = (plen[i] > 0) ? pend[i][0] : 1'b0;
         chk({pfx, " load_ready"}, 64'(ao[i][4]), 64'(erdy));
         chk({pfx, " dout"},       64'(ao[i][3]), 64'(ed));
         chk({pfx, " dout_valid"}, 64'(ao[i][2]), 64'(plen[i] > 0));
         chk({pfx, " last"},       64'(ao[i][1]), 64'(plen[i] == 1));
         chk({pfx, " busy"},       64'(ao[i][0]), 64'(plen[i] > 0));
         rdy_s[i] = ao[i][4];
         if (ao[i][2]) begin
            cap[i]  = {cap[i][62:0], ao[i][3]};
            lcap[i] = {lcap[i][62:0], ao[i][1]};
            ncap[i]++;
         end
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            w   = (i == 0) ? 4 : 8;
            lvi = (i == 0) ? lv4 : lv8;
            di  = (i == 0) ? {4'b0, d4} : d8;
            erdy = (plen[i] == 0) || (plen[i] == 1 && sen);
            if (sen && plen[i] > 0) begin
               pend[i] = pend[i] >> 1;
               plen[i]--;
            end
            if (lvi && erdy) begin
               for (int k = 0; k < w; k++)
                  pend[i][plen[i] + k] = msb ? di[w-1-k] : di[k];
               plen[i] += w;
            end
         end
      end
      #1;
   endtask

   // Present a word and hold it until the DUT takes it; returns cycles waited
   task automatic load(input int i, input logic [7:0] d, input logic m, output int waited);
      bit got = 0;
      waited = 0;
      if (i == 0) begin lv4 = 1'b1; d4 = d[3:0]; end
      else        begin lv8 = 1'b1; d8 = d;      end
      msb = m;
      for (int t = 0; t < 40; t++) begin
         tick();
         waited++;
         if (rdy_s[i]) begin got = 1; break; end
      end
      if (!got) chk("load handshake timeout", 64'(0), 64'(1));
      if (i == 0) lv4 = 1'b0; else lv8 = 1'b0;
   endtask

   task automatic expect_stream(input string nm, input int i, input int s, input int n,
                                input logic [63:0] bits, input logic [63:0] lasts);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      chk({nm, " length"}, 64'(ncap[i] - s), 64'(n));
      chk({nm, " bits"},   cap[i] & m,  bits);
      chk({nm, " last"},   lcap[i] & m, lasts);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       m;
      logic [7:0] exp;
   } w8_case_t;

   initial begin
      int s, wt;
      w8_case_t tbl [6];
      tbl[0] = '{8'hA5, 1'b1, 8'hA5};
      tbl[1] = '{8'hA5, 1'b0, 8'hA5};
      tbl[2] = '{8'h81, 1'b1, 8'h81};
      tbl[3] = '{8'h81, 1'b0, 8'h81};
      tbl[4] = '{8'h03, 1'b1, 8'h03};
      tbl[5] = '{8'h03, 1'b0, 8'hC0};

      for (int i = 0; i < 2; i++) begin
         cap[i] = '0; lcap[i] = '0; ncap[i] = 0; rdy_s[i] = 1'b0;
      end
      model_clear();
      lv4 = 0; lv8 = 0; sen = 1; msb = 1; d4 = '0; d8 = '0;
      rst = 1'b0;
      #1;
      chk("reset outputs w4", 64'({r4, o4, v4, l4, b4}), 64'(5'b10000));
      chk("reset outputs w8", 64'({r8, o8, v8, l8, b8}), 64'(5'b10000));
      tick(); tick();
      rst = 1'b1;
      tick();

      // MSB-first 1100
      s = ncap[0];
      load(0, 8'h0C, 1'b1, wt);
      repeat (5) tick();
      expect_stream("msb 1100", 0, s, 4, 64'b1100, 64'b0001);
      chk("busy after frame", 64'(b4), 64'(0));

      // LSB-first 1100
      s = ncap[0];
      load(0, 8'h0C, 1'b0, wt);
      repeat (5) tick();
      expect_stream("lsb 1100", 0, s, 4, 64'b0011, 64'b0001);

      // Stall two cycles after the second bit
      s = ncap[0];
      load(0, 8'h0A, 1'b1, wt);
      tick(); tick();
      sen = 1'b0;
      tick();
      chk("stall dout", 64'(o4), 64'(1));
      chk("stall last", 64'(l4), 64'(0));
      tick();
      sen = 1'b1;
      repeat (5) tick();
      expect_stream("stall 1010", 0, s, 6, 64'b101110, 64'b000001);

      // Back-to-back 1010 then 0110
      s = ncap[0];
      load(0, 8'h0A, 1'b1, wt);
      load(0, 8'h06, 1'b1, wt);
      chk("b2b second accept wait", 64'(wt), 64'(4));
      repeat (5) tick();
      expect_stream("b2b", 0, s, 8, 64'b10100110, 64'b00010001);

      // Ignored load mid-frame, then reset mid-frame
      s = ncap[0];
      load(0, 8'h01, 1'b1, wt);
      tick();
      lv4 = 1'b1; d4 = 4'hF;
      tick();
      rst = 1'b0; lv4 = 1'b0;
      model_clear();
      #1;
      chk("mid-frame reset outputs", 64'({r4, o4, v4, l4, b4}), 64'(5'b10000));
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("ignored word not captured", 64'(v4), 64'(0));
      expect_stream("aborted 0001", 0, s, 2, 64'b00, 64'b00);

      // WIDTH=8 sweep
      foreach (tbl[j]) begin
         s = ncap[1];
         load(1, tbl[j].d, tbl[j].m, wt);
         repeat (9) tick();
         expect_stream($sformatf("w8 %0h order %0d", tbl[j].d, tbl[j].m), 1, s, 8,
                       64'(tbl[j].exp), 64'h01);
      end

      // Random traffic on both widths, source holds word until taken
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst) begin
            rst = 1'b1;
         end else begin
            if (lv4 && rdy_s[0]) lv4 = 1'b0;
            if (lv8 && rdy_s[1]) lv8 = 1'b0;
         end
         sen = ($urandom_range(3) != 0);
         msb = 1'($urandom_range(1));
         if (!lv4 && $urandom_range(1) == 1) begin
            lv4 = 1'b1; d4 = 4'($urandom);
         end
         if (!lv8 && $urandom_range(1) == 1) begin
            lv8 = 1'b1; d8 = 8'($urandom);
         end
         if ($urandom_range(499) == 0) begin
            rst = 1'b0; lv4 = 1'b0; lv8 = 1'b0;
            model_clear();
         end
      end
      rst = 1'b1; lv4 = 1'b0; lv8 = 1'b0; sen = 1'b1;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
      $finish;
   end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter, successor to the team's fixed 4-bit PISO.
- Adds:
  - generic WIDTH;
  - per-frame selectable bit order;
  - valid/ready load handshake;
  - shift-enable stall;
  - frame-boundary flags;
  - gapless back-to-back frames.
- Sits between a parallel word source (register file, FIFO) and a serial line driver/encoder.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (rst = 0 resets).
- load_valid  input  1  source presents a word on din.
- load_ready  output  1  block can accept a word this cycle.
- din  input  WIDTH  parallel word, captured on handshake.
- msb_first  input  1  bit order for the word being loaded, sampled with din; 1 = MSB first, 0 = LSB first.
- shift_en  input  1  consumer takes the current bit this cycle; 0 = stall.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout carries a frame bit.
- last  output  1  dout is the final bit of the frame.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- State machine has two states:
  - IDLE: no frame. dout = 0, dout_valid = 0, last = 0, busy = 0, load_ready = 1.
  - SHIFT: sreg holds the remaining bits and cnt counts bits already consumed (0..WIDTH-1).
    - dout = dir ? sreg[WIDTH-1] : sreg[0]; dir is msb_first as registered at load.
    - dout_valid = 1, busy = 1.
    - last = (cnt == WIDTH-1).
- Accept:
  - A load is accepted when load_valid && load_ready on a rising edge.
  - On accept: sreg <= din, dir <= msb_first, cnt <= 0, state <= SHIFT.
  - The first bit appears on dout the cycle after accept (latency 1).
- Consume:
  - A bit is consumed in SHIFT when shift_en = 1 at the edge.
  - On consume, sreg shifts toward the output end and zero-fills: left when dir = 1, right when dir = 0. cnt increments.
  - With shift_en held high, a frame occupies exactly WIDTH cycles.
- Stall: with shift_en = 0, sreg, cnt, dout, dout_valid and last all hold.
- Frame end: when the bit with cnt == WIDTH-1 is consumed:
  - if a load is accepted on the same edge, go to SHIFT with the new word (no idle gap);
  - otherwise go to IDLE.
- load_ready definition:
  - load_ready = (state == IDLE) || (state == SHIFT && cnt == WIDTH-1 && shift_en).
  - It is combinational from state, cnt and shift_en; it has no path from load_valid.
- Loads outside that window:
  - load_valid while load_ready = 0 is ignored; din is not captured.
  - The source must hold load_valid and din until it sees ready.
- Changes to msb_first mid-frame have no effect on the current frame.
- Reset:
  - Asynchronous; on rst = 0, state = IDLE, sreg = 0, cnt = 0, dir = 1.
  - Outputs after reset: dout = 0, dout_valid = 0, last = 0, busy = 0, load_ready = 1.
  - Reset mid-frame aborts the frame; remaining bits are discarded and no last is issued.
- Compatibility: WIDTH = 4 with msb_first = 1 and shift_en tied high reproduces the legacy 4-bit PISO bit sequence.

Decomposition:
- Shared package piso_pkg holds:
  - state encoding localparams ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - order constants ORDER_LSB = 1'b0, ORDER_MSB = 1'b1.
- No sub-module is needed; the bit counter and shift register are small enough to stay inline.

Test Plan:
- Basic MSB-first: WIDTH = 4, reset, then load 4'b1100 with msb_first = 1 and shift_en = 1.
  - Required: dout = 1,1,0,0 on the 4 cycles after accept.
  - Required: last high on the 4th bit only; busy low the next cycle.
- LSB-first: load 4'b1100 with msb_first = 0.
  - Required: dout = 0,0,1,1; dout_valid high for exactly 4 cycles.
- Stall: load 4'b1010 MSB-first and drop shift_en for 2 cycles after the 2nd bit.
  - Required: dout holds 1 and last stays 0 during the stall.
  - Required: the full sequence is 1,0,(1,1 held),1,0; total frame length 6 cycles.
- Back-to-back: load 4'b1010, hold load_valid with 4'b0110 next.
  - Required: load_ready pulses only on the last-bit cycle.
  - Required: dout = 1,0,1,0,0,1,1,0 contiguous; dout_valid never drops; last high on bits 4 and 8.
- Ignored load and reset mid-frame: assert load_valid with 4'b1111 on the 2nd bit of a 4'b0001 frame; then pull rst low on the 3rd bit.
  - Required: the 1111 word is not captured.
  - Required: after reset, all outputs are 0 and load_ready = 1 immediately.
- Width sweep: WIDTH = 8, load 8'hA5 MSB-first, then 8'hA5 LSB-first.
  - Required: dout = 1,0,1,0,0,1,0,1 in both orders (8'hA5 is a palindrome).
  - Then repeat with 8'h81 and 8'h03: 8'h03 MSB-first gives 0,0,0,0,0,0,1,1; LSB-first gives 1,1,0,0,0,0,0,0.
